// File: rtl/reset_sequencer_pkg.sv
// Shared types and width helpers for the reset sequencer.
// Exports seq_state_t plus clog2_min1()/max2() for widths.
package reset_sequencer_pkg;

  typedef enum logic [2:0] {
    HOLD,
    WAIT,
    GAP,
    DONE,
    ERROR
  } seq_state_t;

  function automatic int clog2_min1(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Stage-reset bundle between the sequencer and the stages.
// master: stimulus/stage side; slave: the sequencer.
interface reset_sequencer_if
  import reset_sequencer_pkg::*;
#(
  parameter int NUM_STAGES = 4,
  parameter int EW = clog2_min1(NUM_STAGES)
);
  logic                  SOFT_RST_REQ;
  logic [NUM_STAGES-1:0] STAGE_READY;
  logic [NUM_STAGES-1:0] STAGE_RSTN;
  logic                  SEQ_DONE;
  logic                  SEQ_ERROR;
  logic [EW-1:0]         ERR_STAGE;

  modport master (
    output SOFT_RST_REQ, STAGE_READY,
    input  STAGE_RSTN, SEQ_DONE, SEQ_ERROR, ERR_STAGE
  );

  modport slave (
    input  SOFT_RST_REQ, STAGE_READY,
    output STAGE_RSTN, SEQ_DONE, SEQ_ERROR, ERR_STAGE
  );
endinterface

// File: rtl/rst_seq_timer.sv
// Saturating up-counter with clear; expired when count hits limit-1.
// Ports: clk, rst_n (sync), clr, en, limit in; expired out.
module rst_seq_timer #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         expired
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // The edge that sees limit-1 is the limit-th edge since clear.
  assign expired = (cnt_q == (limit - W'(1)));
endmodule

// File: rtl/reset_sequencer.sv
// Ordered release of stage resets with timeout/ready-loss detect.
// Ports: CLK, RSTN (sync, active low), bus (slave modport).
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int NUM_STAGES    = 4,
  parameter int RELEASE_DELAY = 8,
  parameter int TIMEOUT       = 256
) (
  input logic               CLK,
  input logic               RSTN,
  reset_sequencer_if.slave  bus
);
  localparam int IW = clog2_min1(NUM_STAGES);
  localparam int TW = clog2_min1(max2(RELEASE_DELAY, TIMEOUT) + 1);
  localparam logic [IW-1:0] LAST = IW'(NUM_STAGES - 1);

  seq_state_t            state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NUM_STAGES-1:0] rstn_q, rstn_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [IW-1:0]         err_stage_q, err_stage_d;

  logic          tmr_clr, tmr_en, tmr_exp;
  logic [TW-1:0] tmr_limit;
  logic          ready_sel;
  logic [IW-1:0] low_drop;

  rst_seq_timer #(.W(TW)) u_timer (
    .clk     (CLK),
    .rst_n   (RSTN),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .limit   (tmr_limit),
    .expired (tmr_exp)
  );

  always_comb begin
    ready_sel = 1'b0;
    low_drop  = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (idx_q == IW'(i)) ready_sel = bus.STAGE_READY[i];
    end
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (!bus.STAGE_READY[i]) low_drop = IW'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rstn_d      = rstn_q;
    done_d      = done_q;
    err_d       = err_q;
    err_stage_d = err_stage_q;
    tmr_clr     = 1'b0;
    tmr_en      = 1'b0;
    tmr_limit   = (state_q == WAIT) ? TW'(TIMEOUT)
                                    : TW'(RELEASE_DELAY);
    if (bus.SOFT_RST_REQ) begin
      state_d     = HOLD;
      idx_d       = '0;
      rstn_d      = '0;
      done_d      = 1'b0;
      err_d       = 1'b0;
      err_stage_d = '0;
      tmr_clr     = 1'b1;
    end else begin
      unique case (state_q)
        HOLD, GAP: begin
          if (tmr_exp) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
              if (idx_q == IW'(i)) rstn_d[i] = 1'b1;
            end
            state_d = WAIT;
            tmr_clr = 1'b1;
          end else begin
            tmr_en = 1'b1;
          end
        end
        WAIT: begin
          // Ready wins over a timer expiring on the same edge.
          if (ready_sel) begin
            tmr_clr = 1'b1;
            if (idx_q == LAST) begin
              state_d = DONE;
            end else begin
              idx_d   = idx_q + IW'(1);
              state_d = GAP;
            end
          end else if (tmr_exp) begin
            state_d     = ERROR;
            err_d       = 1'b1;
            err_stage_d = idx_q;
          end else begin
            tmr_en = 1'b1;
          end
        end
        DONE: begin
          done_d = 1'b1;
          if (!(&bus.STAGE_READY)) begin
            state_d     = ERROR;
            done_d      = 1'b0;
            err_d       = 1'b1;
            err_stage_d = low_drop;
          end
        end
        ERROR: begin
          state_d = ERROR;
        end
        default: begin
          state_d = HOLD;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q     <= HOLD;
      idx_q       <= '0;
      rstn_q      <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_stage_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rstn_q      <= rstn_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_stage_q <= err_stage_d;
    end
  end

  assign bus.STAGE_RSTN = rstn_q;
  assign bus.SEQ_DONE   = done_q;
  assign bus.SEQ_ERROR  = err_q;
  assign bus.ERR_STAGE  = err_stage_q;
endmodule
